// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side FIFO controller that serialises W_DATA_WIDTH producer words into MEM_WIDTH beats.
// Define FIFO_WR_CTRL_OVF_EN to build the sticky overflow register; otherwise overflow is tied low.
module fifo_wr_ctrl #(
    parameter int W_DATA_WIDTH = 16,
    parameter int MEM_WIDTH    = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_request,
    input  logic [W_DATA_WIDTH-1:0] wr_data,
    output logic                    wr_ready,
    input  logic [ADDR_WIDTH:0]     rd_ptr,
    output logic [ADDR_WIDTH:0]     wr_ptr,
    output logic                    mem_wr_en,
    output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
    output logic [MEM_WIDTH-1:0]    mem_wr_data,
    output logic [ADDR_WIDTH:0]     free_cnt,
    output logic                    full_flag,
    output logic                    almost_full,
    output logic                    overflow,
    input  logic                    ovf_clr,
    output logic                    dbg_state
);

    localparam int RATIO  = W_DATA_WIDTH / MEM_WIDTH;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PW     = ADDR_WIDTH + 1;

    localparam logic [PW-1:0]     DEPTH_P   = PW'(DEPTH);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(RATIO - 1);
    localparam logic [PW:0]       RATIO_X   = (PW + 1)'(RATIO);

    // Handshake: a word transfers at a falling edge where wr_request && wr_ready;
    // wr_ready never depends on wr_request, and a burst, once accepted, always completes.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                  state;
    logic [BEAT_W-1:0]       beat;
    logic [W_DATA_WIDTH-1:0] data_q;
    logic [PW-1:0]           used;
    logic [MEM_WIDTH-1:0]    slice;
    logic                    last;
    logic                    accept;

    assign used     = wr_ptr - rd_ptr;
    assign free_cnt = DEPTH_P - used;
    assign last     = (state == BURST) && (beat == BEAT_LAST);

    // free_cnt - last < RATIO, rearranged so the subtraction can never wrap
    assign full_flag   = ({1'b0, free_cnt} < (RATIO_X + {{PW{1'b0}}, last}));
    assign almost_full = (int'(free_cnt) <= AFULL_THRESH);
    assign wr_ready    = ((state == IDLE) || last) && !full_flag;
    assign accept      = wr_request && wr_ready;

    always_comb begin
        slice = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (beat == BEAT_W'(i)) begin
                slice = data_q[i*MEM_WIDTH +: MEM_WIDTH];
            end
        end
    end

    assign mem_wr_en   = (state == BURST);
    assign mem_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign mem_wr_data = mem_wr_en ? slice : '0;
    assign dbg_state   = state;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            beat   <= '0;
            data_q <= '0;
            wr_ptr <= '0;
        end else begin
            if (state == BURST) begin
                wr_ptr <= wr_ptr + 1'b1;
                beat   <= beat + 1'b1;
            end
            // A new word on the last beat chains straight into the next burst.
            if (accept) begin
                data_q <= wr_data;
                beat   <= '0;
                state  <= BURST;
            end else if (last) begin
                beat  <= '0;
                state <= IDLE;
            end
        end
    end

`ifdef FIFO_WR_CTRL_OVF_EN
    logic ovf_q;

    // Setting wins over a simultaneous clear so a drop is never lost.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (wr_request && !wr_ready && (state == IDLE) && full_flag) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign overflow = ovf_q;
`else
    logic unused_ok;

    assign unused_ok = &{1'b0, ovf_clr};
    assign overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed and random bench for fifo_wr_ctrl, checked against a beat-queue model.
// Define FIFO_WR_CTRL_OVF_EN for both files to cover the sticky overflow flag.
module tb_fifo_wr_ctrl;

    localparam int WD    = 16;
    localparam int MW    = 8;
    localparam int AW    = 4;
    localparam int AFT   = 2;
    localparam int RATIO = WD / MW;
    localparam int DEPTH = 2 ** AW;
    localparam int PM    = 2 * DEPTH;
`ifdef FIFO_WR_CTRL_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic          clk = 1'b1;
    logic          reset;
    logic          wr_request;
    logic [WD-1:0] wr_data;
    logic          wr_ready;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_ptr;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [MW-1:0] mem_wr_data;
    logic [AW:0]   free_cnt;
    logic          full_flag;
    logic          almost_full;
    logic          overflow;
    logic          ovf_clr;
    logic          dbg_state;

    fifo_wr_ctrl #(
        .W_DATA_WIDTH(WD),
        .MEM_WIDTH   (MW),
        .ADDR_WIDTH  (AW),
        .AFULL_THRESH(AFT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_request (wr_request),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_ptr     (rd_ptr),
        .wr_ptr     (wr_ptr),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .free_cnt   (free_cnt),
        .full_flag  (full_flag),
        .almost_full(almost_full),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    endtask

    // Model: beats still to be written, oldest first; the word is reserved in full at acceptance.
    logic [MW-1:0] exp_q[$];
    int            m_wptr = 0;
    bit            m_ovf  = 1'b0;

    function automatic int m_free();
        return (DEPTH - ((m_wptr - int'(rd_ptr)) & (PM - 1))) & (PM - 1);
    endfunction

    function automatic bit m_full();
        int last_beat = (exp_q.size() == 1) ? 1 : 0;
        return (m_free() - last_beat) < RATIO;
    endfunction

    function automatic bit m_ready();
        return (exp_q.size() <= 1) && !m_full();
    endfunction

    initial forever begin
        @(negedge clk or posedge reset);
        if (reset) begin
            exp_q.delete();
            m_wptr = 0;
            m_ovf  = 1'b0;
        end else begin
            bit            acc;
            bit            set_ovf;
            logic [WD-1:0] w;
            acc     = wr_request && m_ready();
            set_ovf = OVF_ON && wr_request && !m_ready() && (exp_q.size() == 0) && m_full();
            if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                m_wptr = (m_wptr + 1) % PM;
            end
            if (acc) begin
                w = wr_data;
                for (int k = 0; k < RATIO; k++) begin
                    exp_q.push_back(w[MW-1:0]);
                    w = w >> MW;
                end
            end
            if (set_ovf) m_ovf = 1'b1;
            else if (OVF_ON && ovf_clr) m_ovf = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        #3;
        check("wr_ptr",      32'(wr_ptr),      32'(m_wptr[AW:0]));
        check("mem_wr_addr", 32'(mem_wr_addr), 32'(m_wptr[AW-1:0]));
        check("mem_wr_en",   32'(mem_wr_en),   32'(exp_q.size() != 0));
        check("mem_wr_data", 32'(mem_wr_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
        check("free_cnt",    32'(free_cnt),    32'(m_free()));
        check("full_flag",   32'(full_flag),   32'(m_full()));
        check("almost_full", 32'(almost_full), 32'(m_free() <= AFT));
        check("wr_ready",    32'(wr_ready),    32'(m_ready()));
        check("overflow",    32'(overflow),    32'(m_ovf));
        check("dbg_state",   32'(dbg_state),   32'(exp_q.size() != 0));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Holds the word until the controller takes it; returns at the drive point after acceptance.
    task automatic send(input logic [WD-1:0] d);
        bit done = 1'b0;
        wr_request = 1'b1;
        wr_data    = d;
        for (int t = 0; t < 64 && !done; t++) begin
            #2;
            done = wr_ready;
            cyc();
        end
        check("send_accept", 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        n_total++;
        $display("FAIL watchdog: got no completion, expected finish before 1ms");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        int occ;
        int rd_prob;
        reset      = 1'b0;
        wr_request = 1'b0;
        wr_data    = '0;
        rd_ptr     = '0;
        ovf_clr    = 1'b0;
        #1 reset = 1'b1;

        // Reset values, during and just after reset
        cyc(); #2;
        check("rst_wr_ptr", 32'(wr_ptr), 32'd0);
        check("rst_en", 32'(mem_wr_en), 32'd0);
        check("rst_ready", 32'(wr_ready), 32'd1);
        cyc(); reset = 1'b0; #2;
        check("init_wr_ptr", 32'(wr_ptr), 32'd0);
        check("init_free", 32'(free_cnt), 32'd16);
        check("init_full", 32'(full_flag), 32'd0);
        check("init_ready", 32'(wr_ready), 32'd1);
        check("init_en", 32'(mem_wr_en), 32'd0);
        check("init_data", 32'(mem_wr_data), 32'd0);
        check("init_addr", 32'(mem_wr_addr), 32'd0);
        check("init_ovf", 32'(overflow), 32'd0);

        // Single word 16'hBEEF: low byte first
        cyc(); wr_request = 1'b1; wr_data = 16'hBEEF;
        cyc(); wr_request = 1'b0; #2;
        check("beef_b0_en", 32'(mem_wr_en), 32'd1);
        check("beef_b0_addr", 32'(mem_wr_addr), 32'd0);
        check("beef_b0_data", 32'(mem_wr_data), 32'hEF);
        cyc(); #2;
        check("beef_b1_addr", 32'(mem_wr_addr), 32'd1);
        check("beef_b1_data", 32'(mem_wr_data), 32'hBE);
        cyc(); #2;
        check("beef_done_en", 32'(mem_wr_en), 32'd0);
        check("beef_wr_ptr", 32'(wr_ptr), 32'd2);
        check("beef_free", 32'(free_cnt), 32'd14);

        // Request held for three words: strobe stays high without a bubble
        cyc(); wr_request = 1'b1; wr_data = 16'($urandom);
        for (int i = 1; i <= 6; i++) begin
            cyc();
            wr_data = 16'($urandom);
            if (i == 6) wr_request = 1'b0;
            #2;
            check("held_no_bubble", 32'(mem_wr_en), 32'd1);
        end
        cyc(); #2;
        check("held_wr_ptr", 32'(wr_ptr), 32'd8);
        check("held_free", 32'(free_cnt), 32'd8);
        check("held_afull", 32'(almost_full), 32'd0);

        // Fill to eight words total with the reader parked at 0
        cyc();
        for (int i = 0; i < 4; i++) send(16'($urandom));
        wr_request = 1'b0;
        cyc(); cyc(); #2;
        check("fill_wr_ptr", 32'(wr_ptr), 32'h10);
        check("fill_full", 32'(full_flag), 32'd1);
        check("fill_ready", 32'(wr_ready), 32'd0);
        check("fill_free", 32'(free_cnt), 32'd0);
        check("fill_afull", 32'(almost_full), 32'd1);

        // Reader frees two slots: one more word fits and wraps to address 0
        cyc(); rd_ptr = 5'd2; #2;
        check("drain_free", 32'(free_cnt), 32'd2);
        check("drain_ready", 32'(wr_ready), 32'd1);
        check("drain_afull", 32'(almost_full), 32'd1);
        cyc();
        send(16'h1234);
        wr_request = 1'b0; #2;
        check("wrap_b0_addr", 32'(mem_wr_addr), 32'd0);
        check("wrap_b0_data", 32'(mem_wr_data), 32'h34);
        cyc(); #2;
        check("wrap_b1_addr", 32'(mem_wr_addr), 32'd1);
        check("wrap_b1_data", 32'(mem_wr_data), 32'h12);
        cyc(); #2;
        check("wrap_wr_ptr", 32'(wr_ptr), 32'h12);
        check("wrap_full", 32'(full_flag), 32'd1);

        // Requests while full: dropped, and flagged when the overflow register is built
        cyc(); wr_request = 1'b1;
        cyc(); wr_request = 1'b0; #2;
        check("ovf_set", 32'(overflow), 32'(OVF_ON));
        check("ovf_no_ptr_move", 32'(wr_ptr), 32'h12);
        cyc(); #2;
        check("ovf_sticky", 32'(overflow), 32'(OVF_ON));
        cyc(); ovf_clr = 1'b1;
        cyc(); ovf_clr = 1'b0; #2;
        check("ovf_cleared", 32'(overflow), 32'd0);
        cyc(); wr_request = 1'b1; ovf_clr = 1'b1;
        cyc(); wr_request = 1'b0; ovf_clr = 1'b0; #2;
        check("ovf_set_beats_clr", 32'(overflow), 32'(OVF_ON));
        cyc(); ovf_clr = 1'b1;
        cyc(); ovf_clr = 1'b0;

        // Reset during beat 0 discards the rest of the burst at once
        rd_ptr = 5'd18;
        send(16'hA55A);
        wr_request = 1'b0;
        #1 reset = 1'b1; rd_ptr = 5'd0;
        #1;
        check("mid_rst_en", 32'(mem_wr_en), 32'd0);
        check("mid_rst_wr_ptr", 32'(wr_ptr), 32'd0);
        check("mid_rst_data", 32'(mem_wr_data), 32'd0);
        cyc(); reset = 1'b0; #2;
        check("post_rst_en", 32'(mem_wr_en), 32'd0);
        cyc(); #2;
        check("post_rst_wr_ptr", 32'(wr_ptr), 32'd0);
        check("post_rst_free", 32'(free_cnt), 32'd16);

        // Random traffic: slow reader first (fills up), then a fast one
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if ($urandom_range(0, 599) == 0) begin
                reset      = 1'b1;
                rd_ptr     = '0;
                wr_request = 1'b0;
                cyc();
                reset = 1'b0;
            end
            rd_prob    = (c < 1500) ? 3 : 1;
            wr_request = ($urandom_range(0, 3) != 0);
            wr_data    = 16'($urandom);
            ovf_clr    = ($urandom_range(0, 15) == 0);
            occ        = (m_wptr - int'(rd_ptr)) & (PM - 1);
            if (occ > 0 && $urandom_range(0, rd_prob) == 0)
                rd_ptr = rd_ptr + 5'($urandom_range(1, (occ > 2) ? 2 : occ));
        end
        cyc();
        wr_request = 1'b0;
        ovf_clr    = 1'b0;
        repeat (4) cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
